// File: rtl/fraction_divider.sv
// fraction_divider: iterative radix-2 restoring divide / square-root significand datapath.
// Square root is only built when FRACTION_DIVIDER_SQRT_EN is defined.
module fraction_divider #(
  parameter int ITERATIONS = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [23:0] dividend_fraction,
  input  logic [23:0] divisor_fraction,
  input  logic [9:0]  exponent_in,
  input  logic        exponent_odd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  op_out,
  output logic [48:0] normalized_fraction,
  output logic [26:0] remainder,
  output logic [9:0]  normalized_exponent
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;
  localparam logic [4:0] LAST    = 5'(ITERATIONS - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [26:0] rem;
  logic [25:0] quo;
  logic [23:0] divisor;
  logic [9:0]  exponent;
  logic        is_sqrt;

  logic        last;
  logic        supported;
  logic        div_lt;
  logic        div_ge;
  logic [26:0] div_kept;
  logic [26:0] div_rem_init;
  logic [26:0] rem_next;
  logic [25:0] quo_next;

  assign in_ready = (state == IDLE);
  assign last     = (cnt == LAST);
  assign div_lt   = dividend_fraction < divisor_fraction;

  // Pre-normalize so the quotient lands in [1,2).
  assign div_rem_init = div_lt ? {2'd0, dividend_fraction, 1'b0}
                               : {3'd0, dividend_fraction};

`ifdef FRACTION_DIVIDER_SQRT_EN
  logic [51:0] radicand;
  logic [51:0] radicand_init;
  logic [28:0] sq_wide;
  logic [28:0] sq_trial;
  logic [28:0] sq_kept;
  logic        sq_ge;
  logic        sq_unused;

  // Radicand aligned so 26 root bits consume all 52 bits.
  assign radicand_init = exponent_odd ? {dividend_fraction, 28'd0}
                                      : {1'b0, dividend_fraction, 27'd0};
  assign sq_wide   = {rem, radicand[51:50]};
  assign sq_trial  = {1'b0, quo, 2'b01};
  assign sq_ge     = sq_wide >= sq_trial;
  assign sq_kept   = sq_ge ? sq_wide - sq_trial : sq_wide;
  assign sq_unused = ^sq_kept[28:27];
  assign supported = (op == OP_DIV) || (op == OP_SQRT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      radicand <= '0;
    end else if (state == IDLE && in_valid) begin
      radicand <= radicand_init;
    end else if (state == CALC) begin
      radicand <= {radicand[49:0], 2'b00};
    end
  end
`else
  logic sq_unused;

  assign sq_unused = ^{exponent_odd, is_sqrt, quo[25]};
  assign supported = (op == OP_DIV);
`endif

  always_comb begin
    div_ge   = rem >= {3'd0, divisor};
    div_kept = div_ge ? rem - {3'd0, divisor} : rem;
    rem_next = last ? div_kept : {div_kept[25:0], 1'b0};
    quo_next = {quo[24:0], div_ge};
`ifdef FRACTION_DIVIDER_SQRT_EN
    if (is_sqrt) begin
      rem_next = sq_kept[26:0];
      quo_next = {quo[24:0], sq_ge};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      rem                 <= '0;
      quo                 <= '0;
      divisor             <= '0;
      exponent            <= '0;
      is_sqrt             <= 1'b0;
      out_valid           <= 1'b0;
      op_out              <= '0;
      normalized_fraction <= '0;
      remainder           <= '0;
      normalized_exponent <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_out <= op;
            cnt    <= '0;
            quo    <= '0;
            if (!supported) begin
              state               <= DONE;
              normalized_fraction <= '0;
              remainder           <= '0;
              normalized_exponent <= '0;
            end else begin
              state   <= CALC;
              is_sqrt <= (op == OP_SQRT);
              divisor <= divisor_fraction;
              if (op == OP_SQRT) begin
                rem      <= '0;
                exponent <= exponent_in;
              end else begin
                rem      <= div_rem_init;
                exponent <= div_lt ? exponent_in - 10'd1
                                   : exponent_in;
              end
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (last) begin
            state               <= DONE;
            out_valid           <= 1'b1;
            normalized_fraction <= {1'b0, quo_next, 22'd0};
            remainder           <= rem_next;
            normalized_exponent <= exponent;
          end
        end
        DONE: begin
          // Unsupported ops arrive here with out_valid still low.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_divider.sv
// tb_fraction_divider: table-driven scoreboard bench for fraction_divider.
// Expected results come from an integer arithmetic model of the quotient/root.
module tb_fraction_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [23:0] dividend_fraction;
  logic [23:0] divisor_fraction;
  logic [9:0]  exponent_in;
  logic        exponent_odd;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  op_out;
  logic [48:0] normalized_fraction;
  logic [26:0] remainder;
  logic [9:0]  normalized_exponent;

  always #5 clk = ~clk;

  fraction_divider #(.ITERATIONS(26)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .op                  (op),
    .dividend_fraction   (dividend_fraction),
    .divisor_fraction    (divisor_fraction),
    .exponent_in         (exponent_in),
    .exponent_odd        (exponent_odd),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .op_out              (op_out),
    .normalized_fraction (normalized_fraction),
    .remainder           (remainder),
    .normalized_exponent (normalized_exponent)
  );

  typedef struct {
    logic [2:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [9:0]  e;
    logic        odd;
    logic [25:0] q_hand;
    logic [25:0] q_mask;
    int          rem_nz;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [48:0] frac;
    logic [26:0] rem;
    logic [9:0]  exp;
    int          lat;
  } res_t;

  res_t sb[$];
  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo = 0;
    longint unsigned hi = 64'd1 << 27;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic res_t model(input vec_t v);
    res_t r;
    longint unsigned num, q, rm;
    r.op = v.op; r.frac = '0; r.rem = '0; r.exp = '0; r.lat = 1;
    if (v.op == 3'd3) begin
      num = (v.a < v.b) ? {39'd0, v.a, 1'b0} : {40'd0, v.a};
      num = num << 25;
      q = num / {40'd0, v.b};
      rm = num % {40'd0, v.b};
      r.frac = {1'b0, q[25:0], 22'd0};
      r.rem = rm[26:0];
      r.exp = (v.a < v.b) ? v.e - 10'd1 : v.e;
      r.lat = 26;
    end
`ifdef FRACTION_DIVIDER_SQRT_EN
    else if (v.op == 3'd4) begin
      num = v.odd ? {12'd0, v.a, 28'd0} : {13'd0, v.a, 27'd0};
      q = isqrt(num);
      rm = num - q * q;
      r.frac = {1'b0, q[25:0], 22'd0};
      r.rem = rm[26:0];
      r.exp = v.e;
      r.lat = 26;
    end
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic [23:0] a,
                              input logic [23:0] b, input logic [9:0] e,
                              input logic odd, input logic [25:0] qh,
                              input logic [25:0] qm, input int nz);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.e = e; v.odd = odd;
    v.q_hand = qh; v.q_mask = qm; v.rem_nz = nz;
    return v;
  endfunction

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input vec_t v, input bit hold);
    int   cyc;
    res_t e;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("in_ready_idle", in_ready, 1);
    op = v.op; dividend_fraction = v.a; divisor_fraction = v.b;
    exponent_in = v.e; exponent_odd = v.odd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(v));
    check("in_ready_busy", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    check("latency", cyc, e.lat);
    check("op_out", op_out, e.op);
    check("fraction", normalized_fraction, e.frac);
    check("remainder", remainder, e.rem);
    check("exponent", normalized_exponent, e.exp);
    if (v.q_mask != 0)
      check("q_hand", normalized_fraction[47:22] & v.q_mask,
            v.q_hand & v.q_mask);
    if (v.rem_nz == 0) check("rem_zero", remainder, 0);
    if (v.rem_nz == 1) check("rem_nonzero", remainder != 0, 1);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_fraction", normalized_fraction, e.frac);
        check("hold_remainder", remainder, e.rem);
        check("hold_exponent", normalized_exponent, e.exp);
      end
    end
    drain();
  endtask

  task automatic check_zero(input string name);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_op_out"}, op_out, 0);
    check({name, "_fraction"}, normalized_fraction, 0);
    check({name, "_remainder"}, remainder, 0);
    check({name, "_exponent"}, normalized_exponent, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0;
    dividend_fraction = '0; divisor_fraction = '0;
    exponent_in = '0; exponent_odd = 1'b0;

    vecs.push_back(mk(3'd3, 24'hC00000, 24'h800000, 10'd5, 0, 26'h3000000, 26'h3FFFFFF, 0));
    vecs.push_back(mk(3'd3, 24'h800000, 24'hC00000, 10'd5, 0, 26'h2AAAAAA, 26'h3FFFFFF, 1));
    vecs.push_back(mk(3'd3, 24'hABCDEF, 24'hABCDEF, 10'd77, 0, 26'h2000000, 26'h3FFFFFF, 0));
    vecs.push_back(mk(3'd3, 24'h800000, 24'hFFFFFF, 10'd0, 0, 26'h0, 26'h0, 1));
    vecs.push_back(mk(3'd3, 24'hFFFFFF, 24'h800001, 10'd100, 0, 26'h0, 26'h0, 2));
    vecs.push_back(mk(3'd7, 24'hC00000, 24'h800000, 10'd9, 1, 26'h0, 26'h0, 0));
    vecs.push_back(mk(3'd0, 24'hFFFFFF, 24'h800000, 10'd3, 0, 26'h0, 26'h0, 0));
`ifdef FRACTION_DIVIDER_SQRT_EN
    vecs.push_back(mk(3'd4, 24'h800000, 24'h0, 10'd12, 0, 26'h2000000, 26'h3FFFFFF, 0));
    vecs.push_back(mk(3'd4, 24'h800000, 24'h0, 10'd12, 1, 26'h2D40000, 26'h3FC0000, 1));
    vecs.push_back(mk(3'd4, 24'hFFFFFF, 24'h0, 10'd40, 1, 26'h0, 26'h0, 2));
    vecs.push_back(mk(3'd4, 24'hC80000, 24'h0, 10'd2, 0, 26'h0, 26'h0, 2));
`else
    vecs.push_back(mk(3'd4, 24'h800000, 24'h800000, 10'd12, 1, 26'h0, 26'h3FFFFFF, 0));
`endif
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(3'd3, 24'($urandom) | 24'h800000,
                        24'($urandom) | 24'h800000,
                        10'($urandom), 0, 26'h0, 26'h0, 2));

    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_zero("reset");

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], i == 1);

    // Abort mid-calculation with an asynchronous reset pulse.
    v = vecs[1];
    op = v.op; dividend_fraction = v.a; divisor_fraction = v.b;
    exponent_in = v.e; exponent_odd = v.odd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(v));
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    #1;
    reset_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check_zero("abort_after");
    run_op(vecs[0], 1'b0);
    run_op(vecs[3], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fraction_divider.md
# fraction_divider

Iterative radix-2 divide/square-root fraction datapath. It sits directly upstream of the rounding stage. It accepts normalized 1.23 significands and produces a left-aligned 49-bit `normalized_fraction`, a 27-bit `remainder` for sticky-bit generation, and an adjusted exponent. One operation is in flight at a time, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `ITERATIONS`, default 26: quotient/root bits generated (1 integer, 23 fraction, guard, round). Fixed at 26 for this format.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  3  3'd3 = divide, 3'd4 = square root, others unsupported.
- `dividend_fraction`  in  24  1.23 significand, bit 23 must be 1; it is the radicand for sqrt.
- `divisor_fraction`  in  24  1.23 significand, bit 23 must be 1; ignored for sqrt.
- `exponent_in`  in  10  exponent from upstream; for sqrt it is already halved.
- `exponent_odd`  in  1  sqrt only: radicand carries an odd exponent.
- `out_valid`  out  1  result held on outputs.
- `out_ready`  in  1  downstream accepts the result.
- `op_out`  out  3  registered `op`.
- `normalized_fraction`  out  49  [xx.47 bits]; quotient/root in [47:22]; [48] and [21:0] always 0.
- `remainder`  out  27  final partial remainder; nonzero means inexact.
- `normalized_exponent`  out  10  adjusted exponent.

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE and clears every output register and the iteration counter to 0.
- IDLE → CALC when `in_valid` is high with a supported op. IDLE → DONE when `in_valid` is high with an unsupported op; that result is all-zero, with `op_out` still registered.
- CALC runs 26 iterations, then enters DONE. DONE → IDLE on `out_valid && out_ready`.
- Divide pre-normalization at accept:
  - If `dividend_fraction < divisor_fraction`, the partial remainder is initialized to dividend<<1 and the exponent to `exponent_in - 1`.
  - Otherwise the partial remainder is the dividend and the exponent is `exponent_in`.
  - The quotient is then in [1,2).
- Divide iteration (restoring): if rem ≥ divisor, rem -= divisor and shift in q bit 1; else shift in 0. Then rem <<= 1, except after the final iteration. The final rem goes to `remainder`.
- Sqrt at accept: the radicand is the significand, shifted left 1 when `exponent_odd` is set. It is aligned so the root in [1,2) yields 26 bits. The exponent is `exponent_in` unchanged.
- Sqrt iteration (restoring digit recurrence):
  - rem = (rem<<2) | next two radicand bits.
  - trial = (root<<2) | 1.
  - If rem ≥ trial: rem -= trial, root = (root<<1) | 1. Else root <<= 1.
- Internal arithmetic is at least 27 bits wide. With legal inputs the final remainder always fits in 27 bits.
- Illegal significands (bit 23 clear): numeric result is undefined, but the handshake and latency are unchanged.

## Timing
- Accept edge is E. Iterations happen on edges E+1..E+26. `out_valid` is high from after edge E+26 onward.
- Latency is 26 cycles for supported ops. Unsupported ops give `out_valid` after edge E+1.
- Outputs are registered and stay stable while `out_valid && !out_ready`.
- `in_ready` is low in CALC and DONE. There is no same-cycle accept on the cycle a result drains; the next accept is possible one cycle after the drain.
- Asserting `reset_n` low mid-CALC or in DONE aborts immediately. Outputs return to 0 and the state to IDLE, with no partial result emitted.
- Throughput is one operation per 28 cycles with `out_ready` tied high.

## Configuration
- `FRACTION_DIVIDER_SQRT_EN`:
  - Defined: op 3'd4 performs square root as specified.
  - Undefined: the sqrt recurrence logic is removed, and op 3'd4 is treated as unsupported (zero result, 1-cycle path). Divide behaviour and timing are identical in both builds.

## Test plan
- Divide 24'hC00000 / 24'h800000, `exponent_in` = 10'd5 → `normalized_fraction[47:22]` = 26'h3000000, `remainder` = 0, exponent 5, `out_valid` 26 cycles after accept.
- Divide 24'h800000 / 24'hC00000, exponent 5 → [47:22] = 26'h2AAAAAA, `remainder` ≠ 0, exponent 4.
- Sqrt 24'h800000 with `exponent_odd` = 0 → [47:22] = 26'h2000000, `remainder` = 0. Same input with `exponent_odd` = 1 → [47:40] = 8'hB5, `remainder` ≠ 0.
- Backpressure: hold `out_ready` low 5 cycles after `out_valid` → outputs stable, `in_ready` low; raise `out_ready` → IDLE next cycle, then the next op is accepted.
- Pulse `reset_n` low at iteration 10 → all outputs 0 and `in_ready` high after release; a following divide completes normally.
- op 3'd7, and op 3'd4 without `FRACTION_DIVIDER_SQRT_EN` → zero result, `out_valid` one cycle after accept.
